// File: rtl/rx_ifm_pkg.sv
// Shared definitions for the RX frame output controller: FSM encoding,
// control-word layout and the helper that builds each control word.
package rx_ifm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PASS = 3'd1,
    ST_DROP = 3'd2,
    ST_CTRL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int          CTRL_WORDS       = 6;
  localparam logic [31:0] CTRL_WORD0       = 32'h5000_0000;
  localparam int          W3_CSUM_BAD_BIT  = 7;
  localparam int          W3_CSUM_OK_BIT   = 6;
  localparam int          W3_TRUNC_BIT     = 5;
  localparam int          INFO_DROP_BIT    = 7;
  localparam int          INFO_CSUM_OK_BIT = 0;
  localparam int          BYTE_CNT_W       = 16;

  // Returns {last, be[3:0], word[31:0]} for control word idx.
  function automatic logic [36:0] ctrl_word(input logic [2:0]  idx,
                                            input logic        csum_ok,
                                            input logic        trunc,
                                            input logic [15:0] byte_cnt);
    logic [31:0] w;
    logic        last;
    w    = '0;
    last = 1'b0;
    case (idx)
      3'd0: w = CTRL_WORD0;
      3'd3: begin
        w[W3_CSUM_BAD_BIT] = ~csum_ok;
        w[W3_CSUM_OK_BIT]  = csum_ok;
        w[W3_TRUNC_BIT]    = trunc;
      end
      3'd5: begin
        w[15:0] = byte_cnt;
        last    = 1'b1;
      end
      default: w = '0;
    endcase
    return {last, 4'hF, w};
  endfunction

endpackage

// File: rtl/keep_cnt.sv
// Population count of a byte-enable vector: number of valid bytes in a beat.
module keep_cnt #(
  parameter int C_KEEP_WIDTH = 8,
  parameter int C_OUT_W      = $clog2(C_KEEP_WIDTH + 1)
) (
  input  logic [C_KEEP_WIDTH-1:0] keep,
  output logic [C_OUT_W-1:0]      count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < C_KEEP_WIDTH; i++) begin
      count = count + C_OUT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/rx_frame_out_ctrl.sv
// Forwards or drops received frames from the data FIFO, truncates oversize
// frames, appends a six-word control record per forwarded frame and keeps stats.
module rx_frame_out_ctrl
  import rx_ifm_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_KEEP_WIDTH = C_DATA_WIDTH / 8,
  parameter int C_MAX_BYTES  = 9600,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                                   s2mm_clk,
  input  logic                                   s2mm_resetn,
  input  logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]     data_fifo_rdata,
  input  logic                                   data_fifo_empty,
  output logic                                   data_fifo_rden,
  input  logic [7:0]                             info_fifo_rdata,
  input  logic                                   info_fifo_empty,
  output logic                                   info_fifo_rden,
  output logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]     good_fifo_wdata,
  output logic                                   good_fifo_wren,
  input  logic                                   good_fifo_afull,
  output logic [36:0]                            ctrl_fifo_wdata,
  output logic                                   ctrl_fifo_wren,
  input  logic                                   ctrl_fifo_afull,
  output logic [C_CNT_WIDTH-1:0]                 stat_good_frames,
  output logic [C_CNT_WIDTH-1:0]                 stat_drop_frames,
  output logic [C_CNT_WIDTH-1:0]                 stat_trunc_frames,
  output logic [2:0]                             dbg_state
);

  localparam int          BEAT_W    = C_DATA_WIDTH + C_KEEP_WIDTH + 1;
  localparam int          KC_W      = $clog2(C_KEEP_WIDTH + 1);
  localparam logic [31:0] MAX_BYTES = 32'(C_MAX_BYTES);
  localparam logic [2:0]  LAST_IDX  = 3'(CTRL_WORDS - 1);

  state_t                  state_q, state_d;
  logic                    drop_q, drop_d;
  logic                    csum_ok_q, csum_ok_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]              ctrl_idx_q, ctrl_idx_d;
  logic                    trunc_q, trunc_d;
  logic                    info_rden_q, info_rden_d;
  logic                    good_wren_q, good_wren_d;
  logic [BEAT_W-1:0]       good_wdata_q, good_wdata_d;
  logic                    ctrl_wren_q, ctrl_wren_d;
  logic [36:0]             ctrl_wdata_q, ctrl_wdata_d;
  logic [C_CNT_WIDTH-1:0]  stat_good_q, stat_good_d;
  logic [C_CNT_WIDTH-1:0]  stat_drop_q, stat_drop_d;
  logic [C_CNT_WIDTH-1:0]  stat_trunc_q, stat_trunc_d;

  logic                    data_pop;
  logic [C_KEEP_WIDTH-1:0] beat_keep;
  logic                    beat_last;
  logic [KC_W-1:0]         keep_bytes;
  logic [BYTE_CNT_W:0]     byte_sum;
  logic [BYTE_CNT_W-1:0]   byte_sat;
  logic                    over_max;
  logic                    unused_info_bits;

  assign beat_keep        = data_fifo_rdata[C_DATA_WIDTH +: C_KEEP_WIDTH];
  assign beat_last        = data_fifo_rdata[BEAT_W-1];
  assign unused_info_bits = &{1'b0, info_fifo_rdata[6:1]};

  keep_cnt #(
    .C_KEEP_WIDTH (C_KEEP_WIDTH),
    .C_OUT_W      (KC_W)
  ) u_keep_cnt (
    .keep  (beat_keep),
    .count (keep_bytes)
  );

  // Saturating running byte count; compared against the limit after saturation.
  assign byte_sum = {1'b0, byte_cnt_q} + {{(BYTE_CNT_W + 1 - KC_W){1'b0}}, keep_bytes};
  assign byte_sat = byte_sum[BYTE_CNT_W] ? {BYTE_CNT_W{1'b1}} : byte_sum[BYTE_CNT_W-1:0];
  assign over_max = {{(32 - BYTE_CNT_W){1'b0}}, byte_sat} > MAX_BYTES;

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    csum_ok_d    = csum_ok_q;
    byte_cnt_d   = byte_cnt_q;
    ctrl_idx_d   = ctrl_idx_q;
    trunc_d      = trunc_q;
    info_rden_d  = 1'b0;
    good_wren_d  = 1'b0;
    good_wdata_d = good_wdata_q;
    ctrl_wren_d  = 1'b0;
    ctrl_wdata_d = ctrl_wdata_q;
    stat_good_d  = stat_good_q;
    stat_drop_d  = stat_drop_q;
    stat_trunc_d = stat_trunc_q;
    data_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        drop_d     = info_fifo_rdata[INFO_DROP_BIT];
        csum_ok_d  = info_fifo_rdata[INFO_CSUM_OK_BIT];
        byte_cnt_d = '0;
        ctrl_idx_d = '0;
        trunc_d    = 1'b0;
        if (!info_fifo_empty) begin
          if (info_fifo_rdata[INFO_DROP_BIT]) begin
            state_d = ST_DROP;
          end else if (!good_fifo_afull) begin
            state_d = ST_PASS;
          end
        end
      end
      ST_PASS: begin
        if (!data_fifo_empty && !good_fifo_afull) begin
          data_pop   = 1'b1;
          byte_cnt_d = byte_sat;
          // Once over the limit, the rest of the frame is consumed silently.
          if (trunc_q || over_max) begin
            trunc_d = 1'b1;
          end else begin
            good_wren_d  = 1'b1;
            good_wdata_d = data_fifo_rdata;
          end
          if (beat_last) begin
            state_d     = ST_CTRL;
            info_rden_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!data_fifo_empty) begin
          data_pop = 1'b1;
          if (beat_last) begin
            state_d     = ST_DONE;
            info_rden_d = 1'b1;
          end
        end
      end
      ST_CTRL: begin
        if (!ctrl_fifo_afull) begin
          ctrl_wren_d  = 1'b1;
          ctrl_wdata_d = ctrl_word(ctrl_idx_q, csum_ok_q, trunc_q, byte_cnt_q);
          if (ctrl_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            ctrl_idx_d = ctrl_idx_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        if (drop_q) begin
          stat_drop_d = stat_drop_q + C_CNT_WIDTH'(1);
        end else if (trunc_q) begin
          stat_trunc_d = stat_trunc_q + C_CNT_WIDTH'(1);
        end else begin
          stat_good_d = stat_good_q + C_CNT_WIDTH'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s2mm_clk) begin
    if (!s2mm_resetn) begin
      state_q      <= ST_IDLE;
      drop_q       <= 1'b0;
      csum_ok_q    <= 1'b0;
      byte_cnt_q   <= '0;
      ctrl_idx_q   <= '0;
      trunc_q      <= 1'b0;
      info_rden_q  <= 1'b0;
      good_wren_q  <= 1'b0;
      good_wdata_q <= '0;
      ctrl_wren_q  <= 1'b0;
      ctrl_wdata_q <= '0;
      stat_good_q  <= '0;
      stat_drop_q  <= '0;
      stat_trunc_q <= '0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      csum_ok_q    <= csum_ok_d;
      byte_cnt_q   <= byte_cnt_d;
      ctrl_idx_q   <= ctrl_idx_d;
      trunc_q      <= trunc_d;
      info_rden_q  <= info_rden_d;
      good_wren_q  <= good_wren_d;
      good_wdata_q <= good_wdata_d;
      ctrl_wren_q  <= ctrl_wren_d;
      ctrl_wdata_q <= ctrl_wdata_d;
      stat_good_q  <= stat_good_d;
      stat_drop_q  <= stat_drop_d;
      stat_trunc_q <= stat_trunc_d;
    end
  end

  assign data_fifo_rden    = data_pop;
  assign info_fifo_rden    = info_rden_q;
  assign good_fifo_wren    = good_wren_q;
  assign good_fifo_wdata   = good_wdata_q;
  assign ctrl_fifo_wren    = ctrl_wren_q;
  assign ctrl_fifo_wdata   = ctrl_wdata_q;
  assign stat_good_frames  = stat_good_q;
  assign stat_drop_frames  = stat_drop_q;
  assign stat_trunc_frames = stat_trunc_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_rx_frame_out_ctrl.sv
// Directed bench for rx_frame_out_ctrl: FWFT FIFO models feed the DUT, a
// negedge monitor logs pops and writes, each scenario task checks its results.
module tb_rx_frame_out_ctrl;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int BW = DW + KW + 1;

  logic          s2mm_clk = 1'b0;
  logic          s2mm_resetn = 1'b0;
  logic [BW-1:0] data_fifo_rdata;
  logic          data_fifo_empty;
  logic          data_fifo_rden;
  logic [7:0]    info_fifo_rdata;
  logic          info_fifo_empty;
  logic          info_fifo_rden;
  logic [BW-1:0] good_fifo_wdata;
  logic          good_fifo_wren;
  logic          good_fifo_afull = 1'b0;
  logic [36:0]   ctrl_fifo_wdata;
  logic          ctrl_fifo_wren;
  logic          ctrl_fifo_afull = 1'b0;
  logic [31:0]   stat_good_frames, stat_drop_frames, stat_trunc_frames;
  logic [2:0]    dbg_state;

  rx_frame_out_ctrl #(
    .C_DATA_WIDTH (DW),
    .C_KEEP_WIDTH (KW),
    .C_MAX_BYTES  (64),
    .C_CNT_WIDTH  (32)
  ) dut (
    .s2mm_clk          (s2mm_clk),
    .s2mm_resetn       (s2mm_resetn),
    .data_fifo_rdata   (data_fifo_rdata),
    .data_fifo_empty   (data_fifo_empty),
    .data_fifo_rden    (data_fifo_rden),
    .info_fifo_rdata   (info_fifo_rdata),
    .info_fifo_empty   (info_fifo_empty),
    .info_fifo_rden    (info_fifo_rden),
    .good_fifo_wdata   (good_fifo_wdata),
    .good_fifo_wren    (good_fifo_wren),
    .good_fifo_afull   (good_fifo_afull),
    .ctrl_fifo_wdata   (ctrl_fifo_wdata),
    .ctrl_fifo_wren    (ctrl_fifo_wren),
    .ctrl_fifo_afull   (ctrl_fifo_afull),
    .stat_good_frames  (stat_good_frames),
    .stat_drop_frames  (stat_drop_frames),
    .stat_trunc_frames (stat_trunc_frames),
    .dbg_state         (dbg_state)
  );

  always #5 s2mm_clk = ~s2mm_clk;

  logic [BW-1:0] dq[$];
  logic [7:0]    iq[$];
  logic [BW-1:0] sent[$];
  logic [BW-1:0] good_log[$];
  logic [36:0]   ctrl_log[$];
  int            n_pops = 0;
  int            n_info = 0;
  bit            pop_d = 1'b0;
  bit            pop_i = 1'b0;
  int            errors = 0;
  int            checks = 0;

  function automatic void refresh();
    data_fifo_empty = (dq.size() == 0);
    data_fifo_rdata = data_fifo_empty ? '0 : dq[0];
    info_fifo_empty = (iq.size() == 0);
    info_fifo_rdata = info_fifo_empty ? 8'h00 : iq[0];
  endfunction

  function automatic logic [33:0] total_frames();
    return 34'(stat_good_frames) + 34'(stat_drop_frames) + 34'(stat_trunc_frames);
  endfunction

  always @(negedge s2mm_clk) begin
    if (data_fifo_rden) begin pop_d = 1'b1; n_pops++; end
    if (info_fifo_rden) begin pop_i = 1'b1; n_info++; end
    if (good_fifo_wren) good_log.push_back(good_fifo_wdata);
    if (ctrl_fifo_wren) ctrl_log.push_back(ctrl_fifo_wdata);
  end

  always @(posedge s2mm_clk) begin
    #1;
    if (pop_d && dq.size() > 0) void'(dq.pop_front());
    if (pop_i && iq.size() > 0) void'(iq.pop_front());
    pop_d = 1'b0;
    pop_i = 1'b0;
    refresh();
  end

  task automatic step();
    @(posedge s2mm_clk);
    #2;
  endtask

  task automatic start_frame();
    good_log.delete();
    ctrl_log.delete();
    sent.delete();
    n_pops = 0;
    n_info = 0;
  endtask

  task automatic push_frame(input int nbeats, input logic [7:0] last_keep,
                            input logic [7:0] info, input logic [15:0] tag);
    logic [BW-1:0] beat;
    for (int i = 0; i < nbeats; i++) begin
      beat = {(i == nbeats - 1), (i == nbeats - 1) ? last_keep : 8'hFF,
              tag, 16'hBEEF, 32'(i)};
      sent.push_back(beat);
      dq.push_back(beat);
    end
    iq.push_back(info);
    refresh();
  endtask

  task automatic wait_done(input string name);
    logic [33:0] t0;
    bit          ok;
    t0 = total_frames();
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      step();
      if (total_frames() != t0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got no frame completion, expected one within 400 cycles", name);
    end
    step();
  endtask

  task automatic test_reset();
    s2mm_resetn = 1'b0;
    repeat (3) step();
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    checks++;
    if ({data_fifo_rden, info_fifo_rden, good_fifo_wren, ctrl_fifo_wren} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000",
                         {data_fifo_rden, info_fifo_rden, good_fifo_wren, ctrl_fifo_wren});
    end
    checks++;
    if (good_fifo_wdata !== '0 || ctrl_fifo_wdata !== '0) begin
      errors++; $display("FAIL reset_wdata: got good=%h ctrl=%h expected 0", good_fifo_wdata, ctrl_fifo_wdata);
    end
    checks++;
    if ({stat_good_frames, stat_drop_frames, stat_trunc_frames} !== 96'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0",
                         stat_good_frames, stat_drop_frames, stat_trunc_frames);
    end
    s2mm_resetn = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_good_64();
    logic [36:0] exp_ctrl[6];
    exp_ctrl = '{{1'b0, 4'hF, 32'h5000_0000}, {1'b0, 4'hF, 32'h0}, {1'b0, 4'hF, 32'h0},
                 {1'b0, 4'hF, 32'h40}, {1'b0, 4'hF, 32'h0}, {1'b1, 4'hF, 32'h40}};
    start_frame();
    push_frame(8, 8'hFF, 8'h01, 16'h0001);
    wait_done("good64");
    checks++;
    if (good_log.size() != 8) begin
      errors++; $display("FAIL good64_writes: got %0d expected 8", good_log.size());
    end
    for (int i = 0; i < 8 && i < good_log.size(); i++) begin
      checks++;
      if (good_log[i] !== sent[i]) begin
        errors++; $display("FAIL good64_beat%0d: got %h expected %h", i, good_log[i], sent[i]);
      end
    end
    checks++;
    if (ctrl_log.size() != 6) begin
      errors++; $display("FAIL good64_ctrl_count: got %0d expected 6", ctrl_log.size());
    end
    for (int i = 0; i < 6 && i < ctrl_log.size(); i++) begin
      checks++;
      if (ctrl_log[i] !== exp_ctrl[i]) begin
        errors++; $display("FAIL good64_word%0d: got %h expected %h", i, ctrl_log[i], exp_ctrl[i]);
      end
    end
    checks++;
    if (n_pops != 8 || n_info != 1) begin
      errors++; $display("FAIL good64_pops: got pops=%0d info=%0d expected 8/1", n_pops, n_info);
    end
    checks++;
    if (stat_good_frames !== 32'd1) begin
      errors++; $display("FAIL good64_stat: got %0d expected 1", stat_good_frames);
    end
    $display("test_good_64 done: %0d beats, %0d words", good_log.size(), ctrl_log.size());
  endtask

  task automatic test_drop();
    start_frame();
    good_fifo_afull = 1'b1;
    push_frame(3, 8'hFF, 8'h80, 16'h0002);
    wait_done("drop");
    good_fifo_afull = 1'b0;
    checks++;
    if (n_pops != 3 || n_info != 1) begin
      errors++; $display("FAIL drop_pops: got pops=%0d info=%0d expected 3/1", n_pops, n_info);
    end
    checks++;
    if (good_log.size() != 0 || ctrl_log.size() != 0) begin
      errors++; $display("FAIL drop_writes: got good=%0d ctrl=%0d expected 0/0", good_log.size(), ctrl_log.size());
    end
    checks++;
    if (stat_drop_frames !== 32'd1 || stat_good_frames !== 32'd1) begin
      errors++; $display("FAIL drop_stat: got drop=%0d good=%0d expected 1/1", stat_drop_frames, stat_good_frames);
    end
    $display("test_drop done: %0d pops", n_pops);
  endtask

  task automatic test_61_bytes();
    start_frame();
    push_frame(8, 8'h1F, 8'h00, 16'h0003);
    wait_done("len61");
    checks++;
    if (good_log.size() != 8 || ctrl_log.size() != 6) begin
      errors++; $display("FAIL len61_counts: got good=%0d ctrl=%0d expected 8/6", good_log.size(), ctrl_log.size());
    end else begin
      checks++;
      if (ctrl_log[3] !== {1'b0, 4'hF, 32'h80}) begin
        errors++; $display("FAIL len61_word3: got %h expected %h", ctrl_log[3], {1'b0, 4'hF, 32'h80});
      end
      checks++;
      if (ctrl_log[5] !== {1'b1, 4'hF, 32'h3D}) begin
        errors++; $display("FAIL len61_word5: got %h expected %h", ctrl_log[5], {1'b1, 4'hF, 32'h3D});
      end
      checks++;
      if (good_log[7] !== sent[7]) begin
        errors++; $display("FAIL len61_lastbeat: got %h expected %h", good_log[7], sent[7]);
      end
    end
    checks++;
    if (stat_good_frames !== 32'd2) begin
      errors++; $display("FAIL len61_stat: got %0d expected 2", stat_good_frames);
    end
    $display("test_61_bytes done");
  endtask

  task automatic test_trunc();
    start_frame();
    push_frame(10, 8'hFF, 8'h01, 16'h0004);
    wait_done("trunc");
    checks++;
    if (n_pops != 10) begin
      errors++; $display("FAIL trunc_pops: got %0d expected 10", n_pops);
    end
    checks++;
    if (good_log.size() != 8) begin
      errors++; $display("FAIL trunc_writes: got %0d expected 8", good_log.size());
    end
    for (int i = 0; i < 8 && i < good_log.size(); i++) begin
      checks++;
      if (good_log[i] !== sent[i]) begin
        errors++; $display("FAIL trunc_beat%0d: got %h expected %h", i, good_log[i], sent[i]);
      end
    end
    checks++;
    if (ctrl_log.size() != 6) begin
      errors++; $display("FAIL trunc_ctrl_count: got %0d expected 6", ctrl_log.size());
    end else begin
      checks++;
      if (ctrl_log[3] !== {1'b0, 4'hF, 32'h60}) begin
        errors++; $display("FAIL trunc_word3: got %h expected %h", ctrl_log[3], {1'b0, 4'hF, 32'h60});
      end
      checks++;
      if (ctrl_log[5] !== {1'b1, 4'hF, 32'h50}) begin
        errors++; $display("FAIL trunc_word5: got %h expected %h", ctrl_log[5], {1'b1, 4'hF, 32'h50});
      end
    end
    checks++;
    if (stat_trunc_frames !== 32'd1 || stat_good_frames !== 32'd2) begin
      errors++; $display("FAIL trunc_stat: got trunc=%0d good=%0d expected 1/2", stat_trunc_frames, stat_good_frames);
    end
    $display("test_trunc done: %0d pops, %0d writes", n_pops, good_log.size());
  endtask

  task automatic test_backpressure();
    logic [36:0] exp_ctrl[6];
    int          c;
    exp_ctrl = '{{1'b0, 4'hF, 32'h5000_0000}, {1'b0, 4'hF, 32'h0}, {1'b0, 4'hF, 32'h0},
                 {1'b0, 4'hF, 32'h40}, {1'b0, 4'hF, 32'h0}, {1'b1, 4'hF, 32'h40}};
    start_frame();
    push_frame(8, 8'hFF, 8'h01, 16'h0005);
    c = 0;
    fork
      wait_done("backpressure");
      begin
        while (dbg_state != 3'd3 && c < 300) begin
          good_fifo_afull = (c % 3 != 2);
          step();
          c++;
        end
        good_fifo_afull = 1'b0;
        ctrl_fifo_afull = 1'b1;
        repeat (10) step();
        ctrl_fifo_afull = 1'b0;
      end
    join
    checks++;
    if (good_log.size() != 8 || n_pops != 8) begin
      errors++; $display("FAIL bp_writes: got good=%0d pops=%0d expected 8/8", good_log.size(), n_pops);
    end
    for (int i = 0; i < 8 && i < good_log.size(); i++) begin
      checks++;
      if (good_log[i] !== sent[i]) begin
        errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, good_log[i], sent[i]);
      end
    end
    checks++;
    if (ctrl_log.size() != 6) begin
      errors++; $display("FAIL bp_ctrl_count: got %0d expected 6", ctrl_log.size());
    end
    for (int i = 0; i < 6 && i < ctrl_log.size(); i++) begin
      checks++;
      if (ctrl_log[i] !== exp_ctrl[i]) begin
        errors++; $display("FAIL bp_word%0d: got %h expected %h", i, ctrl_log[i], exp_ctrl[i]);
      end
    end
    checks++;
    if (stat_good_frames !== 32'd3) begin
      errors++; $display("FAIL bp_stat: got %0d expected 3", stat_good_frames);
    end
    $display("test_backpressure done: %0d beats, %0d words", good_log.size(), ctrl_log.size());
  endtask

  task automatic test_reset_mid();
    int good_snap;
    int cyc;
    start_frame();
    push_frame(8, 8'hFF, 8'h01, 16'h0006);
    cyc = 0;
    while (n_pops < 2 && cyc < 50) begin step(); cyc++; end
    checks++;
    if (n_pops < 2) begin
      errors++; $display("FAIL rstmid_start: got %0d pops expected at least 2", n_pops);
    end
    s2mm_resetn = 1'b0;
    dq.delete();
    iq.delete();
    refresh();
    step();
    checks++;
    if ({data_fifo_rden, info_fifo_rden, good_fifo_wren, ctrl_fifo_wren} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_strobes: got %b expected 0000",
                         {data_fifo_rden, info_fifo_rden, good_fifo_wren, ctrl_fifo_wren});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL rstmid_state: got %0d expected 0", dbg_state);
    end
    checks++;
    if ({stat_good_frames, stat_drop_frames, stat_trunc_frames} !== 96'd0) begin
      errors++; $display("FAIL rstmid_stats: got %0d/%0d/%0d expected 0/0/0",
                         stat_good_frames, stat_drop_frames, stat_trunc_frames);
    end
    good_snap = good_log.size();
    s2mm_resetn = 1'b1;
    repeat (10) step();
    checks++;
    if (good_log.size() != good_snap || ctrl_log.size() != 0 || n_info != 0) begin
      errors++; $display("FAIL rstmid_quiet: got good=%0d ctrl=%0d info=%0d expected %0d/0/0",
                         good_log.size(), ctrl_log.size(), n_info, good_snap);
    end
    start_frame();
    push_frame(4, 8'hFF, 8'h01, 16'h0007);
    wait_done("recover");
    checks++;
    if (good_log.size() != 4 || ctrl_log.size() != 6) begin
      errors++; $display("FAIL recover_counts: got good=%0d ctrl=%0d expected 4/6", good_log.size(), ctrl_log.size());
    end else begin
      checks++;
      if (ctrl_log[5] !== {1'b1, 4'hF, 32'h20}) begin
        errors++; $display("FAIL recover_word5: got %h expected %h", ctrl_log[5], {1'b1, 4'hF, 32'h20});
      end
    end
    checks++;
    if (stat_good_frames !== 32'd1) begin
      errors++; $display("FAIL recover_stat: got %0d expected 1", stat_good_frames);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    refresh();
    test_reset();
    test_good_64();
    test_drop();
    test_61_bytes();
    test_trunc();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_out_ctrl.md
RX_FRAME_OUT_CTRL -- requirements
Module: rx_frame_out_ctrl

Interface
REQ-001 Parameter C_DATA_WIDTH, default 64: payload bits per beat; multiple of 32.
REQ-002 Parameter C_KEEP_WIDTH, default C_DATA_WIDTH/8: byte-enable bits per beat.
REQ-003 Parameter C_MAX_BYTES, default 9600: largest frame forwarded intact, in bytes.
REQ-004 Parameter C_CNT_WIDTH, default 32: width of the statistics counters.
REQ-005 s2mm_clk  in  1  the only clock; all logic is synchronous to its rising edge.
REQ-006 s2mm_resetn  in  1  reset, synchronous and active-low.
REQ-007 data_fifo_rdata  in  C_DATA_WIDTH+C_KEEP_WIDTH+1  first-word-fall-through beat {last, keep, data}.
REQ-008 data_fifo_empty  in  1  data FIFO empty.
REQ-009 data_fifo_rden  out  1  combinational pop of the data FIFO.
REQ-010 info_fifo_rdata  in  8  per-frame info; bit7 = drop, bit0 = checksum-ok.
REQ-011 info_fifo_empty  in  1  info FIFO empty.
REQ-012 info_fifo_rden  out  1  registered pop of the info FIFO.
REQ-013 good_fifo_wdata  out  C_DATA_WIDTH+C_KEEP_WIDTH+1  registered copy of the popped beat.
REQ-014 good_fifo_wren  out  1  registered write strobe; good_fifo_afull  in  1  almost-full.
REQ-015 ctrl_fifo_wdata  out  37  {last, be[3:0], word[31:0]}; ctrl_fifo_wren  out  1; ctrl_fifo_afull  in  1.
REQ-016 stat_good_frames, stat_drop_frames, stat_trunc_frames  out  C_CNT_WIDTH each  wrapping frame counters.
REQ-017 dbg_state  out  3  current state code.

Function
REQ-018 States: IDLE=0, PASS=1, DROP=2, CTRL=3, DONE=4.
REQ-019 IDLE -> DROP when info_fifo_empty=0 and info bit7=1; IDLE -> PASS when info_fifo_empty=0, info bit7=0 and good_fifo_afull=0; otherwise the FSM stays in IDLE.
REQ-020 The FSM latches info_fifo_rdata on every IDLE cycle; the value latched on the exit cycle applies to the whole frame.
REQ-021 data_fifo_rden is asserted in DROP when data_fifo_empty=0, and in PASS when data_fifo_empty=0 and good_fifo_afull=0; any other condition stalls the FSM with no pop.
REQ-022 good_fifo_wren is asserted one cycle after a PASS pop, with good_fifo_wdata equal to the popped beat; this output latency is fixed at 1.
REQ-023 The byte count is cleared in IDLE and, on each PASS pop, increases by the popcount of keep, saturating at 16'hFFFF.
REQ-024 Truncation: if a PASS beat would push the byte count above C_MAX_BYTES, that beat and every later beat of the frame are popped but not written, the last written beat is not re-marked, and the truncation flag is set.
REQ-025 PASS -> CTRL and DROP -> DONE on a pop whose last bit is 1; info_fifo_rden is asserted exactly one cycle later, for 1 cycle.
REQ-026 In CTRL the FSM emits six words, indices 0..5; word n is written only when ctrl_fifo_afull=0, and the index advances only on a write.
REQ-027 Word 0 = 0x5000_0000; words 1, 2 and 4 = 0.
REQ-028 Word 3: bit7 = ~checksum-ok, bit6 = checksum-ok, bit5 = truncation flag, all other bits 0.
REQ-029 Word 5 has last=1 and [15:0] = the final byte count; be = 4'hF on all six words and last=0 on words 0..4.
REQ-030 CTRL -> DONE after word 5 is written; DONE -> IDLE unconditionally after one cycle.
REQ-031 On DONE, exactly one statistics counter increments: drop for DROP frames, trunc for truncated frames, good otherwise; counters wrap at 2^C_CNT_WIDTH.
REQ-032 A drop frame that arrives while good_fifo_afull=1 is still drained.

Reset
REQ-033 While s2mm_resetn=0 at a clock edge: state=IDLE; data_fifo_rden, info_fifo_rden, good_fifo_wren and ctrl_fifo_wren = 0; the byte count, CTRL index, truncation flag and all stat counters = 0; good_fifo_wdata and ctrl_fifo_wdata = 0.
REQ-034 A reset in the middle of a frame abandons the frame with no further writes and no counter increments.

Structure
REQ-035 The shared package rx_ifm_pkg holds the state encoding, the CTRL word count (6), the word-0 constant and the bit positions used in word 3.
REQ-036 Keep popcount is the sub-module keep_cnt, parametrised by C_KEEP_WIDTH.

Verification
REQ-037 Good 64-byte frame (8 full beats), info=0x01 -> 8 good writes, words 0x5000_0000,0,0,0x40,0,{last,0x0040}; stat_good_frames=1.
REQ-038 Frame with info=0x80, 3 beats -> 3 pops, 0 good/ctrl writes, one info_fifo_rden; stat_drop_frames=1.
REQ-039 61-byte frame, last keep=0x1F, info=0x00 -> word 3 = 0x80, word 5[15:0]=0x003D.
REQ-040 C_MAX_BYTES=64, 80-byte frame -> 8 good writes, word 3 bit5=1; stat_trunc_frames=1.
REQ-041 good_fifo_afull toggled mid-frame and ctrl_fifo_afull held for 10 cycles during CTRL -> no lost or duplicated beats or words.
REQ-042 Reset asserted after beat 2 of a good frame -> all strobes 0 next cycle, state=IDLE, counters 0.
